// File: rtl/pattern_run_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_run_sequencer
//
// Runs one pattern-detection pass over a 1-bit-wide block ROM. It clears the
// detector, then steps ROM addresses 0..DEPTH-1 at a programmable tick rate.
// It absorbs the ROM read latency and hands each bit to the detector with a
// one-cycle valid strobe. At the end of the run it samples the detector's
// match count and converts it to packed BCD for the seven-segment display.
//
// Ports:
//   clock_100Mhz  in   system clock
//   reset         in   asynchronous active-low reset
//   start         in   one-cycle pulse; begins a run, honoured only in IDLE
//   repeat_mode   in   sampled in DONE; 1 restarts the run automatically
//   rom_en        out  ROM enable, high for exactly one cycle per read
//   rom_addr      out  ROM address (holds DEPTH-1 after a run until next CLEAR)
//   rom_data      in   ROM data, valid ROM_LAT cycles after rom_en
//   det_clear     out  one-cycle clear to the detector at run start
//   det_bit       out  bit presented to the detector (holds when not valid)
//   det_valid     out  one-cycle qualifier for det_bit
//   det_count     in   detector match count
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse in the cycle bcd_out shows a new result
//   bcd_out       out  packed BCD {thousands, hundreds, tens, ones}
// -----------------------------------------------------------------------------
module pattern_run_sequencer #(
    parameter int ADDR_W   = 4,          // ROM address width
    parameter int DEPTH    = 16,         // bits per run, at most 2**ADDR_W
    parameter int TICK_DIV = 100000000,  // cycles waited before each ROM read
    parameter int ROM_LAT  = 1,          // ROM read latency, 1..3
    parameter int CNT_W    = 8           // detector count width, at most 13
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              repeat_mode,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              det_clear,
    output logic              det_bit,
    output logic              det_valid,
    input  logic [CNT_W-1:0]  det_count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bcd_out
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_READ,
        S_LAT,
        S_FEED,
        S_SETTLE,
        S_CONV,
        S_DONE
    } state_e;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CONV_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [1:0]        LAT_LAST    = 2'(ROM_LAT - 1);
    localparam logic [1:0]        SETTLE_LAST = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [CONV_W-1:0] CONV_LAST   = CONV_W'(CNT_W - 1);

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [1:0]          lat_q, lat_d;      // shared by LAT and SETTLE
    logic [CONV_W-1:0]   conv_q, conv_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bit_q, bit_d;
    logic [CNT_W-1:0]    bin_q, bin_d;
    // The thousands digit never exceeds 4 before a shift (the count is below
    // 10000), so only bits [14:0] ever need storing between steps; bit 15 can
    // only become 1 on the final step, which goes straight into bcd_out.
    logic [14:0]         bcd_q, bcd_d;
    logic [15:0]         bcd_out_q, bcd_out_d;

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // binary MSB in. The thousands digit is <= 4 here, so it never needs
    // the adjustment.
    logic [11:0]         bcd_adj;
    logic [15:0]         bcd_step;
    logic [CNT_W-1:0]    bin_step;

    always_comb begin
        bcd_adj = bcd_q[11:0];
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    assign bcd_step = {bcd_q[14:12], bcd_adj, bin_q[CNT_W-1]};
    assign bin_step = bin_q << 1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            lat_q     <= '0;
            conv_q    <= '0;
            addr_q    <= '0;
            bit_q     <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            bcd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            lat_q     <= lat_d;
            conv_q    <= conv_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    // NOTE: every variable gets a default before the case statement, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        tick_d    = '0;          // counters rest at 0 outside their own state
        lat_d     = '0;
        conv_d    = '0;
        addr_d    = addr_q;
        bit_d     = bit_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bcd_out_d = bcd_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick_q == TICK_LAST) begin
                    state_d = S_READ;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_READ: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                // Capture on the last latency cycle, when rom_data is valid.
                if (lat_q == LAT_LAST) begin
                    bit_d   = rom_data;
                    state_d = S_FEED;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_FEED: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_SETTLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_SETTLE: begin
                // Two cycles let the detector's registered count catch up
                // with the final bit before it is sampled.
                if (lat_q == SETTLE_LAST) begin
                    bin_d   = det_count;
                    bcd_d   = '0;
                    state_d = S_CONV;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_CONV: begin
                bin_d = bin_step;
                bcd_d = bcd_step[14:0];
                if (conv_q == CONV_LAST) begin
                    // Load the result on entry to DONE so bcd_out is already
                    // updated while done is high.
                    bcd_out_d = bcd_step;
                    state_d   = S_DONE;
                end else begin
                    conv_d = conv_q + 1'b1;
                end
            end
            S_DONE: begin
                if (repeat_mode) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode directly from the registered state, so reset clears
    // them in the same cycle it is asserted.
    assign rom_en    = (state_q == S_READ);
    assign det_clear = (state_q == S_CLEAR);
    assign det_valid = (state_q == S_FEED);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign rom_addr  = addr_q;
    assign det_bit   = bit_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_pattern_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pattern_run_sequencer
//
// Scoreboard bench for pattern_run_sequencer with TICK_DIV=4, ROM_LAT=1,
// DEPTH=16. Stimulus pushes the expected detector feeds and BCD results into
// queues; an independent monitor pops and compares whenever the DUT strobes
// det_valid or done. A synchronous ROM model holds 16'hB6D5.
// -----------------------------------------------------------------------------
module tb_pattern_run_sequencer;

    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int TICK_DIV = 4;
    localparam int ROM_LAT  = 1;
    localparam int CNT_W    = 8;
    localparam int BIT_PERIOD   = TICK_DIV + ROM_LAT + 2;  // 7
    localparam int DONE_LATENCY = 2 + CNT_W + 1;           // 11

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              repeat_mode;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_data;
    logic              det_clear;
    logic              det_bit;
    logic              det_valid;
    logic [CNT_W-1:0]  det_count;
    logic              busy;
    logic              done;
    logic [15:0]       bcd_out;

    always #5 clk = ~clk;

    pattern_run_sequencer #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TICK_DIV(TICK_DIV),
        .ROM_LAT (ROM_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .start       (start),
        .repeat_mode (repeat_mode),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .det_clear   (det_clear),
        .det_bit     (det_bit),
        .det_valid   (det_valid),
        .det_count   (det_count),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out)
    );

    // ROM model: one-cycle read latency. Outside the valid cycle the model
    // shows the complement, so a capture in the wrong cycle is visible.
    logic [15:0] rom_bits = 16'hB6D5;
    logic        rom_q    = 1'b0;
    logic        rom_vld  = 1'b0;

    always @(posedge clk) begin
        rom_vld <= rom_en;
        if (rom_en) rom_q <= rom_bits[rom_addr];
    end
    assign rom_data = rom_vld ? rom_q : ~rom_q;

    // All outputs packed together for the "everything is 0" checks.
    logic [25:0] outs;
    assign outs = {busy, rom_en, det_clear, det_valid, det_bit, done, rom_addr, bcd_out};

    // Scoreboard
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              b;
    } feed_t;

    feed_t       exp_feed_q[$];
    logic [15:0] exp_done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    int cycle        = 0;
    int last_valid   = 0;
    int run_strobes  = 0;
    int rom_en_total = 0;
    int clear_total  = 0;
    int done_total   = 0;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (reset) begin
            if (det_valid) begin
                check("strobe_expected", 32'(exp_feed_q.size() > 0), 1);
                if (exp_feed_q.size() > 0) begin
                    feed_t e;
                    e = exp_feed_q.pop_front();
                    check("strobe_addr", 32'(rom_addr), 32'(e.addr));
                    check("strobe_bit", 32'(det_bit), 32'(e.b));
                end
                if (run_strobes > 0) check("strobe_spacing", cycle - last_valid, BIT_PERIOD);
                last_valid = cycle;
                run_strobes++;
            end
            if (done) begin
                check("done_expected", 32'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    logic [15:0] e;
                    e = exp_done_q.pop_front();
                    check("bcd_out", 32'(bcd_out), 32'(e));
                end
                check("done_latency", cycle - last_valid, DONE_LATENCY);
                done_total++;
            end
            if (det_clear) begin
                check("clear_addr", 32'(rom_addr), 0);
                run_strobes = 0;
                clear_total++;
            end
            if (rom_en) rom_en_total++;
        end
    end

    task automatic push_run(input logic [15:0] exp_bcd);
        for (int i = 0; i < DEPTH; i++) begin
            feed_t e;
            e.addr = ADDR_W'(i);
            e.b    = rom_bits[i];
            exp_feed_q.push_back(e);
        end
        exp_done_q.push_back(exp_bcd);
    endtask

    // One full run. Optionally re-pulses start on the Nth strobe or in the
    // done cycle; both must be ignored.
    task automatic run_one(input logic [CNT_W-1:0] cnt, input logic [15:0] exp_bcd,
                           input int start_at, input bit start_on_done);
        int  k;
        bit  got;
        int  en0, clr0, done0;
        det_count = cnt;
        push_run(exp_bcd);
        en0   = rom_en_total;
        clr0  = clear_total;
        done0 = done_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k   = 0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (det_valid) begin
                k++;
                if (k == start_at) start = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                if (start_on_done) start = 1'b1;
            end
        end
        check("done_seen", 32'(got), 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 32'(busy), 0);
        check("strobes_left", exp_feed_q.size(), 0);
        check("rom_en_per_run", rom_en_total - en0, DEPTH);
        check("clears_per_run", clear_total - clr0, 1);
        check("dones_per_run", done_total - done0, 1);
        exp_feed_q.delete();
        exp_done_q.delete();
    endtask

    initial begin
        bit got;
        int clr0;

        reset       = 1'b0;
        start       = 1'b0;
        repeat_mode = 1'b0;
        det_count   = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs), 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'(outs), 0);
        end
        check("idle_rom_en", rom_en_total, 0);

        // Basic run with conversion, max count with start while busy,
        // zero count with start in the done cycle.
        run_one(8'd203, 16'h0203, 0, 1'b0);
        run_one(8'hFF,  16'h0255, 5, 1'b0);
        run_one(8'h00,  16'h0000, 0, 1'b1);
        check("bcd_hold_idle", 32'(bcd_out), 0);

        // Reset mid-run at rom_addr == 7
        det_count = 8'd42;
        for (int i = 0; i < 7; i++) begin
            feed_t e;
            e.addr = ADDR_W'(i);
            e.b    = rom_bits[i];
            exp_feed_q.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (rom_addr == ADDR_W'(7)) got = 1'b1;
        end
        check("reached_addr7", 32'(got), 1);
        reset = 1'b0;
        #1;
        check("midrun_reset_outputs", 32'(outs), 0);
        check("midrun_busy", 32'(busy), 0);
        check("midrun_strobes", exp_feed_q.size(), 0);
        exp_feed_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 32'(outs), 0);

        // Repeat mode: back-to-back runs, det_clear right after done
        repeat_mode = 1'b1;
        push_run(16'h0042);
        push_run(16'h0042);
        clr0  = clear_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("repeat_done1_seen", 32'(got), 1);
        @(negedge clk);
        check("repeat_clear", 32'(det_clear), 1);
        check("repeat_addr", 32'(rom_addr), 0);
        check("repeat_busy", 32'(busy), 1);
        repeat_mode = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("repeat_done2_seen", 32'(got), 1);
        @(negedge clk);
        check("repeat_busy_end", 32'(busy), 0);
        check("repeat_clears", clear_total - clr0, 2);
        check("repeat_strobes_left", exp_feed_q.size(), 0);
        check("repeat_dones_left", exp_done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
